color_correct_matrix: RTL

COLOR_CORRECT_MATRIX -- requirements
Module: color_correct_matrix

---
 rtl/color_correct_matrix_pkg.sv | 26 ++
 rtl/color_correct_matrix_row.sv | 82 ++++++++
 rtl/color_correct_matrix.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/color_correct_matrix_pkg.sv
// Shared ISP constants for the colour-correction matrix: default widths,
// coefficient addressing and the identity reset value.
package color_correct_matrix_pkg;

    localparam int unsigned CCM_PIX_W    = 12;
    localparam int unsigned CCM_COEF_W   = 12;
    localparam int unsigned CCM_FRAC_W   = 8;
    localparam int unsigned CCM_NUM_COEF = 9;

    typedef enum logic [3:0] {
        CCM_C00 = 4'd0, CCM_C01 = 4'd1, CCM_C02 = 4'd2,
        CCM_C10 = 4'd3, CCM_C11 = 4'd4, CCM_C12 = 4'd5,
        CCM_C20 = 4'd6, CCM_C21 = 4'd7, CCM_C22 = 4'd8
    } ccmAddrE;

    localparam logic [3:0] CCM_ADDR_MAX = CCM_C22;

    // Identity matrix entry: 1.0 on the diagonal, 0 elsewhere.
    function automatic int ccmIdentity(input int unsigned idx, input int unsigned fracW);
        if (idx == int'(CCM_C00) || idx == int'(CCM_C11) || idx == int'(CCM_C22)) begin
            return 1 << fracW;
        end
        return 0;
    endfunction

endpackage

// File: rtl/color_correct_matrix_row.sv
// One output channel of the colour matrix: three products, sum with rounding,
// then shift and clamp. Three pipeline stages, each loaded only by its valid.
module ccm_row #(
    parameter int unsigned PIX_W  = 12,
    parameter int unsigned COEF_W = 12,
    parameter int unsigned FRAC_W = 8
) (
    input  logic              isp_clk,
    input  logic              rst_n,
    input  logic              s1Load,
    input  logic              s2Load,
    input  logic              s3Load,
    input  logic              bypassS2,
    input  logic [PIX_W-1:0]  redIn,
    input  logic [PIX_W-1:0]  greIn,
    input  logic [PIX_W-1:0]  bluIn,
    input  logic [PIX_W-1:0]  passIn,
    input  logic [COEF_W-1:0] coef0,
    input  logic [COEF_W-1:0] coef1,
    input  logic [COEF_W-1:0] coef2,
    output logic [PIX_W-1:0]  pixOut
);

    localparam int unsigned PROD_W = PIX_W + COEF_W + 1;
    localparam int unsigned SUM_W  = PROD_W + 2;

    localparam logic signed [SUM_W-1:0] ROUND_C = SUM_W'(1) <<< (FRAC_W - 1);
    localparam logic signed [SUM_W-1:0] PIX_MAX = SUM_W'((1 << PIX_W) - 1);

    logic signed [PROD_W-1:0] prod0Q, prod1Q, prod2Q;
    logic signed [SUM_W-1:0]  sumQ;
    logic [PIX_W-1:0]         pass1Q, pass2Q;
    logic signed [SUM_W-1:0]  shiftedC;
    logic [PIX_W-1:0]         clampC;

    // Unsigned pixel times signed coefficient, sized so the product never wraps.
    function automatic logic signed [PROD_W-1:0] mulPix(input logic [PIX_W-1:0] pix,
                                                      input logic [COEF_W-1:0] coef);
        logic signed [PROD_W-1:0] pixExt;
        logic signed [PROD_W-1:0] coefExt;
        pixExt  = PROD_W'($signed({1'b0, pix}));
        coefExt = PROD_W'($signed(coef));
        return pixExt * coefExt;
    endfunction

    always_comb begin
        shiftedC = sumQ >>> FRAC_W;
        clampC   = PIX_W'(shiftedC);
        if (shiftedC[SUM_W-1]) begin
            clampC = '0;
        end else if (shiftedC > PIX_MAX) begin
            clampC = '1;
        end
    end

    always_ff @(posedge isp_clk) begin
        if (!rst_n) begin
            prod0Q <= '0;
            prod1Q <= '0;
            prod2Q <= '0;
            pass1Q <= '0;
            sumQ   <= '0;
            pass2Q <= '0;
            pixOut <= '0;
        end else begin
            if (s1Load) begin
                prod0Q <= mulPix(redIn, coef0);
                prod1Q <= mulPix(greIn, coef1);
                prod2Q <= mulPix(bluIn, coef2);
                pass1Q <= passIn;
            end
            if (s2Load) begin
                sumQ   <= SUM_W'(prod0Q) + SUM_W'(prod1Q) + SUM_W'(prod2Q) + ROUND_C;
                pass2Q <= pass1Q;
            end
            if (s3Load) begin
                pixOut <= bypassS2 ? pass2Q : clampC;
            end
        end
    end

endmodule

// File: rtl/color_correct_matrix.sv
// 3x3 colour-correction matrix with double-buffered coefficients that swap
// only at frame boundaries, three-cycle pipeline and per-pixel bypass.
module color_correct_matrix
    import color_correct_matrix_pkg::*;
#(
    parameter int unsigned PIX_W  = CCM_PIX_W,
    parameter int unsigned COEF_W = CCM_COEF_W,
    parameter int unsigned FRAC_W = CCM_FRAC_W
) (
    input  logic              isp_clk,
    input  logic              rst_n,
    input  logic [PIX_W-1:0]  redIn,
    input  logic [PIX_W-1:0]  greIn,
    input  logic [PIX_W-1:0]  bluIn,
    input  logic              dinEn,
    input  logic              frameDoneIn,
    input  logic              cfgWe,
    input  logic [3:0]        cfgAddr,
    input  logic [COEF_W-1:0] cfgData,
    input  logic              bypass,
    output logic [PIX_W-1:0]  redOut,
    output logic [PIX_W-1:0]  greOut,
    output logic [PIX_W-1:0]  bluOut,
    output logic              doutEn,
    output logic              frameDoneOut,
    output logic              cfgPending
);

    logic [COEF_W-1:0] shadowQ [CCM_NUM_COEF];
    logic [COEF_W-1:0] activeQ [CCM_NUM_COEF];
    logic              wrValidC;
    logic              commitC;
    logic              valid1Q, valid2Q;
    logic              frame1Q, frame2Q;
    logic              byp1Q, byp2Q;

    assign wrValidC = cfgWe & (cfgAddr <= CCM_ADDR_MAX);
    assign commitC  = frameDoneIn & cfgPending;

    // Shadow/active banks; a commit takes the pre-write shadow, so a write in
    // the same cycle stays pending for the next frame.
    always_ff @(posedge isp_clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < CCM_NUM_COEF; i++) begin
                shadowQ[i] <= COEF_W'(ccmIdentity(i, FRAC_W));
                activeQ[i] <= COEF_W'(ccmIdentity(i, FRAC_W));
            end
            cfgPending <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < CCM_NUM_COEF; i++) begin
                if (commitC) begin
                    activeQ[i] <= shadowQ[i];
                end
                if (wrValidC && cfgAddr == 4'(i)) begin
                    shadowQ[i] <= cfgData;
                end
            end
            if (wrValidC) begin
                cfgPending <= 1'b1;
            end else if (commitC) begin
                cfgPending <= 1'b0;
            end
        end
    end

    // Side-band shift register running alongside the row datapaths.
    always_ff @(posedge isp_clk) begin
        if (!rst_n) begin
            valid1Q      <= 1'b0;
            valid2Q      <= 1'b0;
            doutEn       <= 1'b0;
            frame1Q      <= 1'b0;
            frame2Q      <= 1'b0;
            frameDoneOut <= 1'b0;
            byp1Q        <= 1'b0;
            byp2Q        <= 1'b0;
        end else begin
            valid1Q      <= dinEn;
            valid2Q      <= valid1Q;
            doutEn       <= valid2Q;
            frame1Q      <= frameDoneIn;
            frame2Q      <= frame1Q;
            frameDoneOut <= frame2Q;
            byp1Q        <= bypass;
            byp2Q        <= byp1Q;
        end
    end

    ccm_row #(.PIX_W(PIX_W), .COEF_W(COEF_W), .FRAC_W(FRAC_W)) uRowRed (
        .isp_clk (isp_clk),
        .rst_n   (rst_n),
        .s1Load  (dinEn),
        .s2Load  (valid1Q),
        .s3Load  (valid2Q),
        .bypassS2(byp2Q),
        .redIn   (redIn),
        .greIn   (greIn),
        .bluIn   (bluIn),
        .passIn  (redIn),
        .coef0   (activeQ[0]),
        .coef1   (activeQ[1]),
        .coef2   (activeQ[2]),
        .pixOut  (redOut)
    );

    ccm_row #(.PIX_W(PIX_W), .COEF_W(COEF_W), .FRAC_W(FRAC_W)) uRowGre (
        .isp_clk (isp_clk),
        .rst_n   (rst_n),
        .s1Load  (dinEn),
        .s2Load  (valid1Q),
        .s3Load  (valid2Q),
        .bypassS2(byp2Q),
        .redIn   (redIn),
        .greIn   (greIn),
        .bluIn   (bluIn),
        .passIn  (greIn),
        .coef0   (activeQ[3]),
        .coef1   (activeQ[4]),
        .coef2   (activeQ[5]),
        .pixOut  (greOut)
    );

    ccm_row #(.PIX_W(PIX_W), .COEF_W(COEF_W), .FRAC_W(FRAC_W)) uRowBlu (
        .isp_clk (isp_clk),
        .rst_n   (rst_n),
        .s1Load  (dinEn),
        .s2Load  (valid1Q),
        .s3Load  (valid2Q),
        .bypassS2(byp2Q),
        .redIn   (redIn),
        .greIn   (greIn),
        .bluIn   (bluIn),
        .passIn  (bluIn),
        .coef0   (activeQ[6]),
        .coef1   (activeQ[7]),
        .coef2   (activeQ[8]),
        .pixOut  (bluOut)
    );

endmodule
